// File: rtl/adbg_or1k_intreg_reader_if.sv
// Handshake and data bundle between the OR1K command decoder, the internal-register
// reader and the TDO mux.
interface adbg_or1k_intreg_reader_if #(
  parameter int INTREG_WIDTH = 2,
  parameter int SEL_WIDTH    = 3
);
  logic                    rd_req_i;
  logic [SEL_WIDTH-1:0]    reg_select_i;
  logic [INTREG_WIDTH-1:0] status_reg_i;
  logic                    shift_en_i;
  logic                    tdo_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    sel_err_o;

  modport master (
    output rd_req_i, reg_select_i, status_reg_i, shift_en_i,
    input  tdo_o, busy_o, done_o, sel_err_o
  );

  modport slave (
    input  rd_req_i, reg_select_i, status_reg_i, shift_en_i,
    output tdo_o, busy_o, done_o, sel_err_o
  );
endinterface

// File: rtl/adbg_or1k_intreg_reader.sv
// Captures the selected OR1K internal register on a read command and shifts it out
// LSB first on TDO, followed by the 32-bit reflected CRC accumulated over the data bits.
//
//  state   | meaning
//  IDLE    | waiting for rd_req_i; tdo_o held low
//  DATA    | shifting captured register bits, CRC accumulates
//  CRC     | shifting the 32 CRC bits out, zero fill
module adbg_or1k_intreg_reader #(
  parameter int                    INTREG_WIDTH = 2,
  parameter int                    SEL_WIDTH    = 3,
  parameter logic [SEL_WIDTH-1:0]  STATUS_SEL   = 3'h1,
  parameter logic [31:0]           CRC_POLY     = 32'hEDB88320
) (
  input  logic                      tck_i,
  input  logic                      rst_i,
  adbg_or1k_intreg_reader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_DATA = 6'(INTREG_WIDTH - 1);
  localparam logic [5:0] LAST_CRC  = 6'd31;

  state_t                  state_q, state_d;
  logic [INTREG_WIDTH-1:0] data_q, data_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [31:0]             crc_q, crc_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    sel_err_q, sel_err_d;
  logic                    sel_hit;
  logic                    fb;

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      crc_q     <= 32'hFFFF_FFFF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    sel_err_d = sel_err_q;
    done_d    = 1'b0;
    sel_hit   = (bus.reg_select_i == STATUS_SEL);
    fb        = crc_q[0] ^ data_q[0];

    unique case (state_q)
      ST_IDLE: begin
        // A shift request coinciding with capture is not consumed here.
        if (bus.rd_req_i) begin
          data_d    = sel_hit ? bus.status_reg_i : '0;
          sel_err_d = ~sel_hit;
          crc_d     = 32'hFFFF_FFFF;
          cnt_d     = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.shift_en_i) begin
          crc_d  = (crc_q >> 1) ^ (fb ? CRC_POLY : 32'h0);
          data_d = data_q >> 1;
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = ST_CRC;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_CRC: begin
        if (bus.shift_en_i) begin
          crc_d = crc_q >> 1;
          if (cnt_q == LAST_CRC) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    bus.tdo_o = 1'b0;
    if (state_q == ST_DATA)     bus.tdo_o = data_q[0];
    else if (state_q == ST_CRC) bus.tdo_o = crc_q[0];
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.sel_err_o = sel_err_q;

endmodule
